uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single UART transmitter.
// Accepts one byte at a time, launches it with a one-cycle tx_dv strobe and
// waits for the transmitter's done pulse, abandoning the transfer on timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer; arbitration open when the transmitter is ready
// LAUNCH    | byte registered, tx_dv asserted for this single cycle
// WAIT_DONE | waiting for tx_done, counting toward TIMEOUT_CYCLES
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [1:0]       grant_q, grant_d;
  logic             ptr_q, ptr_d;        // last requester granted (0 or 1)
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             pick0, pick1;
  logic             accept0, accept1;

  // Round-robin pick: a lone requester wins, otherwise the one not served last.
  always_comb begin
    pick0   = req0_valid && (!req1_valid || ptr_q);
    pick1   = req1_valid && (!req0_valid || !ptr_q);
    accept0 = (state_q == IDLE) && tx_ready && pick0;
    accept1 = (state_q == IDLE) && tx_ready && pick1;
  end

  // Next-state and datapath updates for the transfer sequence.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    to_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept0) begin
          state_d   = LAUNCH;
          tx_byte_d = req0_data;
          grant_d   = 2'b01;
          ptr_d     = 1'b0;
        end else if (accept1) begin
          state_d   = LAUNCH;
          tx_byte_d = req1_data;
          grant_d   = 2'b10;
          ptr_d     = 1'b1;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done arriving on the final count still counts as success.
        if (tx_done) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          grant_d = 2'b00;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_byte_q <= 8'h00;
      grant_q   <= 2'b00;
      ptr_q     <= 1'b1;
      cnt_q     <= '0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
    end
  end

  assign req0_ready  = accept0;
  assign req1_ready  = accept1;
  assign tx_dv       = (state_q == LAUNCH);
  assign tx_byte     = tx_byte_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, a randomized run against a
// transaction-level model, and a serial loop through bench UART models.
module tb_uart_tx_arbiter;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx_dv, busy, timeout_err;
  logic [7:0] tx_byte;
  logic [1:0] grant;
  logic       tx_done, tx_ready;

  // Transmitter side: 0 = driven by tasks, 1 = fixed-latency model, 2 = serial model.
  int         tx_mode = 0;
  int         tx_delay = 8;
  logic       man_done, man_ready;
  logic       model_done, model_ready;
  logic       serial_line;
  logic [7:0] rx_q[$];
  int         rx_bad = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign tx_done  = (tx_mode == 0) ? man_done  : model_done;
  assign tx_ready = (tx_mode == 0) ? man_ready : model_ready;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .tx_ready   (tx_ready),
    .grant      (grant),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  // Transmitter model: fixed-latency done pulse, or 1 clk/bit 8N1 serialiser.
  initial begin : tx_model
    logic [7:0] sh;
    model_done  = 1'b0;
    model_ready = 1'b1;
    serial_line = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mode != 0 && tx_dv === 1'b1) begin
        sh = tx_byte;
        @(posedge clk); #2;
        model_ready = 1'b0;
        if (tx_mode == 1) begin
          repeat (tx_delay - 1) begin @(posedge clk); #2; end
          model_done = 1'b1;
        end else begin
          serial_line = 1'b0;
          for (int i = 0; i < 8; i++) begin @(posedge clk); #2; serial_line = sh[i]; end
          @(posedge clk); #2;
          serial_line = 1'b1;
          model_done  = 1'b1;
        end
        @(posedge clk); #2;
        model_done  = 1'b0;
        model_ready = 1'b1;
      end
    end
  end

  // Receiver model: samples the serial line once per clock on the falling edge.
  initial begin : rx_model
    logic [7:0] rb;
    forever begin
      @(negedge clk);
      if (serial_line === 1'b0) begin
        for (int i = 0; i < 8; i++) begin @(negedge clk); rb[i] = serial_line; end
        @(negedge clk);
        if (serial_line === 1'b1) rx_q.push_back(rb);
        else rx_bad++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    man_done = 1'b0; man_ready = 1'b1; tx_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({tx_dv, busy, timeout_err, grant, tx_byte} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {tx_dv, busy, timeout_err, grant, tx_byte});
    end
    rst = 1'b0;
  endtask

  task automatic test_contention();
    int n;
    logic [7:0] got[4];
    logic [1:0] gs[4];
    logic [7:0] exp_b[4];
    logic [1:0] exp_g[4];
    exp_b = '{8'h11, 8'h22, 8'h11, 8'h22};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    n = 0;
    tx_mode = 1; tx_delay = 8;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk); #1;
      if (tx_dv === 1'b1) begin got[n] = tx_byte; gs[n] = grant; n++; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL contention_count: got %0d want 4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== exp_b[k]) begin
        errors++; $display("FAIL contention_byte[%0d]: got %h want %h", k, got[k], exp_b[k]);
      end
      checks++;
      if (gs[k] !== exp_g[k]) begin
        errors++; $display("FAIL contention_grant[%0d]: got %b want %b", k, gs[k], exp_g[k]);
      end
    end
    for (int c = 0; c < 50 && busy !== 1'b0; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL contention_drain: busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    tx_mode = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    man_ready = 1'b1; req0_valid = 1'b1; req0_data = 8'hA5;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clk); #1;
    checks++;
    if ({tx_dv, tx_byte, grant, busy, req0_ready} !== {1'b1, 8'hA5, 2'b01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single_launch: got %h want %h",
        {tx_dv, tx_byte, grant, busy, req0_ready}, {1'b1, 8'hA5, 2'b01, 1'b1, 1'b0});
    end
    req0_valid = 1'b0;
    @(negedge clk);
    man_done = 1'b1;
    #1;
    checks++;
    if ({tx_dv, busy, grant} !== 4'b0101) begin
      errors++; $display("FAIL single_wait: got %b want 0101", {tx_dv, busy, grant});
    end
    @(negedge clk);
    man_done = 1'b0;
    #1;
    checks++;
    if ({busy, grant, tx_byte} !== {1'b0, 2'b00, 8'hA5}) begin
      errors++; $display("FAIL single_done: got %h want %h", {busy, grant, tx_byte}, {1'b0, 2'b00, 8'hA5});
    end
  endtask

  task automatic test_busy_tx();
    logic [7:0] d;
    d = 8'($urandom);
    @(negedge clk);
    man_ready = 1'b0; req1_valid = 1'b1; req1_data = d;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready, tx_dv, busy} !== 4'b0000) begin
        errors++; $display("FAIL busy_tx_hold[%0d]: got %b want 0000", c, {req0_ready, req1_ready, tx_dv, busy});
      end
      @(negedge clk);
    end
    man_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL busy_tx_accept: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++;
    if ({tx_dv, tx_byte, grant} !== {1'b1, d, 2'b10}) begin
      errors++; $display("FAIL busy_tx_launch: got %h want %h", {tx_dv, tx_byte, grant}, {1'b1, d, 2'b10});
    end
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_tx_done: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    // Run 1: no done in WAIT_DONE (a stray done in LAUNCH must be ignored).
    // Run 2: done on the final counted cycle wins over the timeout.
    for (int run = 0; run < 2; run++) begin
      @(negedge clk);
      man_ready = 1'b1; req0_valid = 1'b1; req0_data = 8'($urandom);
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL timeout_accept[%0d]: got %b want 1", run, req0_ready); end
      for (int i = 1; i <= 19; i++) begin
        @(negedge clk);
        req0_valid = 1'b0;
        man_done = (run == 0) ? (i == 1) : (i == 17);
        #1;
        checks++;
        if ({timeout_err, busy} !== {(run == 0 && i == 18), (i < 18)}) begin
          errors++; $display("FAIL timeout_seq[%0d][%0d]: got %b want %b", run, i,
            {timeout_err, busy}, {(run == 0 && i == 18), (i < 18)});
        end
      end
      man_done = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    man_ready = 1'b1; req1_valid = 1'b1; req1_data = 8'h5C;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({busy, tx_dv, grant} !== 4'b1010) begin
      errors++; $display("FAIL rstmid_wait: got %b want 1010", {busy, tx_dv, grant});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx_dv, busy, timeout_err, grant, tx_byte} !== 13'h0) begin
      errors++; $display("FAIL rstmid_async: got %h want 0", {tx_dv, busy, timeout_err, grant, tx_byte});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'h3A; req1_valid = 1'b1; req1_data = 8'h4B;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rstmid_contention: got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++;
    if ({tx_dv, tx_byte, timeout_err} !== {1'b1, 8'h3A, 1'b0}) begin
      errors++; $display("FAIL rstmid_launch: got %h want %h", {tx_dv, tx_byte, timeout_err}, {1'b1, 8'h3A, 1'b0});
    end
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
  endtask

  // Transaction-level reference: after an acceptance in cycle C with a
  // transmitter done latency D, the launch is in C+1 and the block is free
  // again in C+D+2. Ready follows the round-robin rule whenever free.
  task automatic test_random(input int d);
    int free_at, acc_cycle, last;
    logic v0, v1;
    logic [7:0] d0, d1, pend_byte;
    logic [1:0] pend_grant;
    logic idle, e0, e1;
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tx_mode = 1; tx_delay = d;
    free_at = 0; acc_cycle = -10; last = 1;
    pend_byte = 8'h00; pend_grant = 2'b00;
    for (int t = 0; t < 250; t++) begin
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
      d0 = 8'($urandom); d1 = 8'($urandom);
      req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
      #1;
      idle = (t >= free_at);
      e0 = idle && v0 && (!v1 || last == 1);
      e1 = idle && v1 && (!v0 || last == 0);
      checks++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        errors++; $display("FAIL rand_ready[d=%0d t=%0d]: got %b want %b", d, t, {req0_ready, req1_ready}, {e0, e1});
      end
      checks++;
      if ({tx_dv, busy, grant} !== {(t == acc_cycle + 1), !idle, (idle ? 2'b00 : pend_grant)}) begin
        errors++; $display("FAIL rand_status[d=%0d t=%0d]: got %b want %b", d, t, {tx_dv, busy, grant},
          {(t == acc_cycle + 1), !idle, (idle ? 2'b00 : pend_grant)});
      end
      if (t == acc_cycle + 1) begin
        checks++;
        if (tx_byte !== pend_byte) begin
          errors++; $display("FAIL rand_byte[d=%0d t=%0d]: got %h want %h", d, t, tx_byte, pend_byte);
        end
      end
      if (e0) begin
        acc_cycle = t; pend_byte = d0; pend_grant = 2'b01; last = 0; free_at = t + d + 2;
      end else if (e1) begin
        acc_cycle = t; pend_byte = d1; pend_grant = 2'b10; last = 1; free_at = t + d + 2;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 50 && busy !== 1'b0; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain[d=%0d]: busy got %b want 0", d, busy); end
    repeat (2) @(negedge clk);
    tx_mode = 0;
  endtask

  task automatic test_system_loop();
    int i0, i1, cnt;
    int seen[64];
    for (int k = 0; k < 64; k++) seen[k] = 0;
    i0 = 0; i1 = 0;
    rx_q.delete(); rx_bad = 0;
    tx_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req0_valid = (i0 < 32); req0_data = 8'(2 * i0);
      req1_valid = (i1 < 32); req1_data = 8'(2 * i1 + 1);
      #1;
      if (req0_valid && req0_ready) i0++;
      if (req1_valid && req1_ready) i1++;
      if (i0 == 32 && i1 == 32 && rx_q.size() == 64 && busy === 1'b0) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cnt = rx_q.size();
    checks++;
    if (cnt != 64) begin errors++; $display("FAIL loop_count: got %0d want 64", cnt); end
    checks++;
    if (rx_bad != 0) begin errors++; $display("FAIL loop_framing: got %0d want 0", rx_bad); end
    for (int k = 0; k < cnt; k++) if (rx_q[k] < 8'd64) seen[rx_q[k]]++;
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (seen[k] != 1) begin errors++; $display("FAIL loop_seen[%02h]: got %0d want 1", k, seen[k]); end
    end
    for (int k = 1; k < cnt; k++) begin
      checks++;
      if ((rx_q[k][0] ^ rx_q[k-1][0]) !== 1'b1) begin
        errors++; $display("FAIL loop_alternate[%0d]: got %h after %h want other requester", k, rx_q[k], rx_q[k-1]);
      end
    end
    repeat (3) @(negedge clk);
    tx_mode = 0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_busy_tx();
    test_timeout();
    test_reset_mid();
    test_random(3);
    test_random(int'($urandom_range(1, 12)));
    test_system_loop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
